// File: rtl/boxing_pkg.sv
// Shared types and constants for the boxing game blocks.
package boxing_pkg;

    localparam int unsigned NUM_LEDS = 5;
    localparam int unsigned BCD_W    = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_HIT_FLASH,
        ST_MISS_FLASH,
        ST_GAME_OVER
    } judge_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability debounce, one-cycle press on rising level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Level follows the synced input only after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/punch_judge.sv
// Boxing game judge: hit/miss decision on each press, BCD score, lives and game sequencing.
module punch_judge
    import boxing_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TARGET_IDX      = 4,
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned FLASH_CYCLES    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] led,
    input  logic                btn,
    input  logic                start,
    output bcd_t                score_tens,
    output bcd_t                score_ones,
    output logic [1:0]          lives,
    output logic                playing,
    output logic                flash,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic                game_over
);

    localparam int unsigned FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    judge_state_t  r_state;
    logic [FW-1:0] r_flash_cnt;
    bcd_t          r_tens;
    bcd_t          r_ones;
    logic [1:0]    r_lives;
    logic          r_playing;
    logic          r_flash;
    logic          r_hit;
    logic          r_miss;
    logic          r_over;
    logic          w_press;
    logic          w_target;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(w_press)
    );

    assign w_target = led[TARGET_IDX];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_flash_cnt <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
            r_lives     <= 2'(START_LIVES);
            r_playing   <= 1'b0;
            r_flash     <= 1'b0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_over      <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        r_state   <= ST_PLAY;
                        r_tens    <= '0;
                        r_ones    <= '0;
                        r_lives   <= 2'(START_LIVES);
                        r_playing <= 1'b1;
                        r_over    <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (w_press && w_target) begin
                        r_hit       <= 1'b1;
                        r_state     <= ST_HIT_FLASH;
                        r_flash     <= 1'b1;
                        r_flash_cnt <= '0;
                        // Score saturates at 99; ones carries into tens.
                        if (!(r_tens == 4'd9 && r_ones == 4'd9)) begin
                            if (r_ones == 4'd9) begin
                                r_ones <= '0;
                                r_tens <= r_tens + 4'd1;
                            end else begin
                                r_ones <= r_ones + 4'd1;
                            end
                        end
                    end else if (w_press) begin
                        r_miss  <= 1'b1;
                        r_lives <= (r_lives > 2'd1) ? (r_lives - 2'd1) : 2'd0;
                        if (r_lives <= 2'd1) begin
                            r_state   <= ST_GAME_OVER;
                            r_playing <= 1'b0;
                            r_over    <= 1'b1;
                        end else begin
                            r_state     <= ST_MISS_FLASH;
                            r_flash     <= 1'b1;
                            r_flash_cnt <= '0;
                        end
                    end
                end
                ST_HIT_FLASH, ST_MISS_FLASH: begin
                    if (r_flash_cnt == FW'(FLASH_CYCLES - 1)) begin
                        r_state <= ST_PLAY;
                        r_flash <= 1'b0;
                    end else begin
                        r_flash_cnt <= r_flash_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign score_tens = r_tens;
    assign score_ones = r_ones;
    assign lives      = r_lives;
    assign playing    = r_playing;
    assign flash      = r_flash;
    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;
    assign game_over  = r_over;

endmodule

// File: tb/tb_punch_judge.sv
// Scenario bench for punch_judge with a scoreboard of expected hit/miss events.
module tb_punch_judge;

    logic       clk;
    logic       rst;
    logic [4:0] led;
    logic       btn;
    logic       start;

    logic [3:0] score_tens, score_ones;
    logic [1:0] lives;
    logic       playing, flash, hit_pulse, miss_pulse, game_over;

    logic [3:0] l_tens, l_ones;
    logic [1:0] l_lives;
    logic       l_playing, l_flash, l_hit, l_miss, l_over;

    typedef struct {
        bit hit;
        int tens;
        int ones;
        int lives;
        int flash_cycles;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_err;
    int   m_score;
    int   m_lives;

    int   obs_pulses;
    bit   obs_hit;
    int   obs_tens, obs_ones, obs_lives, obs_flash;

    punch_judge u_dut (
        .clk       (clk),
        .rst       (rst),
        .led       (led),
        .btn       (btn),
        .start     (start),
        .score_tens(score_tens),
        .score_ones(score_ones),
        .lives     (lives),
        .playing   (playing),
        .flash     (flash),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .game_over (game_over)
    );

    // Long flash variant so that a press can land inside a flash window.
    punch_judge #(.FLASH_CYCLES(60)) u_long (
        .clk       (clk),
        .rst       (rst),
        .led       (led),
        .btn       (btn),
        .start     (start),
        .score_tens(l_tens),
        .score_ones(l_ones),
        .lives     (l_lives),
        .playing   (l_playing),
        .flash     (l_flash),
        .hit_pulse (l_hit),
        .miss_pulse(l_miss),
        .game_over (l_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold btn for 'hold' cycles then release for 30; record the first pulse seen on u_dut.
    task automatic punch(input int hold);
        obs_pulses = 0;
        obs_hit    = 0;
        obs_tens   = -1;
        obs_ones   = -1;
        obs_lives  = -1;
        obs_flash  = 0;
        for (int c = 0; c < hold + 30; c++) begin
            btn = (c < hold);
            @(negedge clk);
            if (flash) obs_flash++;
            if (hit_pulse || miss_pulse) begin
                if (obs_pulses == 0) begin
                    obs_hit   = hit_pulse;
                    obs_tens  = int'(score_tens);
                    obs_ones  = int'(score_ones);
                    obs_lives = int'(lives);
                end
                obs_pulses++;
            end
        end
        btn = 1'b0;
    endtask

    task automatic push_expect(input bit hit);
        exp_t e;
        if (hit) begin
            if (m_score < 99) m_score++;
        end else if (m_lives > 0) begin
            m_lives--;
        end
        e.hit          = hit;
        e.tens         = m_score / 10;
        e.ones         = m_score % 10;
        e.lives        = m_lives;
        e.flash_cycles = (!hit && m_lives == 0) ? 0 : 8;
        q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_score = 0;
        m_lives = 3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_score: got %h%h want 00", score_tens, score_ones);
        end
        n_cmp++;
        if (lives !== 2'd3) begin
            n_err++;
            $display("FAIL reset_lives: got %0d want 3", lives);
        end
        n_cmp++;
        if ({playing, flash, hit_pulse, miss_pulse, game_over} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {playing, flash, hit_pulse, miss_pulse, game_over});
        end
    endtask

    task automatic test_hit();
        exp_t e;
        do_start();
        n_cmp++;
        if (playing !== 1'b1 || lives !== 2'd3 || {score_tens, score_ones} !== 8'h00) begin
            n_err++;
            $display("FAIL start_state: got playing=%b lives=%0d score=%h%h want 1/3/00",
                     playing, lives, score_tens, score_ones);
        end
        led = 5'b10000;
        push_expect(1'b1);
        punch(20);
        e = q.pop_front();
        n_cmp++;
        if (obs_pulses !== 1 || obs_hit !== e.hit) begin
            n_err++;
            $display("FAIL hit_pulse: got pulses=%0d hit=%b want 1/%b", obs_pulses, obs_hit, e.hit);
        end
        n_cmp++;
        if (obs_tens !== e.tens || obs_ones !== e.ones || obs_lives !== e.lives) begin
            n_err++;
            $display("FAIL hit_score: got %0d%0d lives=%0d want %0d%0d lives=%0d",
                     obs_tens, obs_ones, obs_lives, e.tens, e.ones, e.lives);
        end
        n_cmp++;
        if (obs_flash !== e.flash_cycles) begin
            n_err++;
            $display("FAIL hit_flash_len: got %0d want %0d", obs_flash, e.flash_cycles);
        end
        n_cmp++;
        if (playing !== 1'b1 || flash !== 1'b0) begin
            n_err++;
            $display("FAIL hit_back_to_play: got playing=%b flash=%b want 1/0", playing, flash);
        end
    endtask

    task automatic test_glitch();
        punch(5);
        n_cmp++;
        if (obs_pulses !== 0) begin
            n_err++;
            $display("FAIL glitch_pulses: got %0d want 0", obs_pulses);
        end
        n_cmp++;
        if (int'(score_tens) !== m_score / 10 || int'(score_ones) !== m_score % 10
            || int'(lives) !== m_lives) begin
            n_err++;
            $display("FAIL glitch_state: got %h%h lives=%0d want %0d lives=%0d",
                     score_tens, score_ones, lives, m_score, m_lives);
        end
    endtask

    task automatic test_miss_game_over();
        exp_t e;
        led = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            push_expect(1'b0);
            punch(20);
            e = q.pop_front();
            n_cmp++;
            if (obs_pulses !== 1 || obs_hit !== e.hit || obs_lives !== e.lives
                || obs_tens !== e.tens || obs_ones !== e.ones) begin
                n_err++;
                $display("FAIL miss_%0d: got pulses=%0d hit=%b lives=%0d score=%0d%0d want 1/%b/%0d/%0d%0d",
                         i, obs_pulses, obs_hit, obs_lives, obs_tens, obs_ones,
                         e.hit, e.lives, e.tens, e.ones);
            end
            n_cmp++;
            if (obs_flash !== e.flash_cycles) begin
                n_err++;
                $display("FAIL miss_flash_%0d: got %0d want %0d", i, obs_flash, e.flash_cycles);
            end
        end
        n_cmp++;
        if (game_over !== 1'b1 || playing !== 1'b0 || lives !== 2'd0) begin
            n_err++;
            $display("FAIL game_over: got over=%b playing=%b lives=%0d want 1/0/0",
                     game_over, playing, lives);
        end
        led = 5'b10000;
        punch(20);
        n_cmp++;
        if (obs_pulses !== 0 || lives !== 2'd0 || int'(score_ones) !== m_score % 10
            || int'(score_tens) !== m_score / 10) begin
            n_err++;
            $display("FAIL over_frozen: got pulses=%0d lives=%0d score=%h%h want 0/0/%0d",
                     obs_pulses, lives, score_tens, score_ones, m_score);
        end
        do_start();
        n_cmp++;
        if (lives !== 2'd3 || {score_tens, score_ones} !== 8'h00 || playing !== 1'b1
            || game_over !== 1'b0) begin
            n_err++;
            $display("FAIL restart: got lives=%0d score=%h%h playing=%b over=%b want 3/00/1/0",
                     lives, score_tens, score_ones, playing, game_over);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        led = 5'b10000;
        for (int i = 1; i <= 100; i++) begin
            push_expect(1'b1);
            punch(20);
            e = q.pop_front();
            n_cmp++;
            if (obs_pulses !== 1 || obs_hit !== 1'b1 || obs_tens !== e.tens
                || obs_ones !== e.ones || obs_lives !== e.lives) begin
                n_err++;
                $display("FAIL sat_hit_%0d: got pulses=%0d hit=%b score=%0d%0d lives=%0d want 1/1/%0d%0d/%0d",
                         i, obs_pulses, obs_hit, obs_tens, obs_ones, obs_lives,
                         e.tens, e.ones, e.lives);
            end
        end
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h99) begin
            n_err++;
            $display("FAIL sat_final: got %h%h want 99", score_tens, score_ones);
        end
    endtask

    task automatic test_flash_press_and_start();
        exp_t e;
        int   l_hits;
        int   l_misses;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        do_start();
        led = 5'b10000;
        push_expect(1'b1);
        l_hits   = 0;
        l_misses = 0;
        // Second rise lands while the long variant is still flashing.
        for (int c = 0; c < 120; c++) begin
            btn = (c < 20) || (c >= 40 && c < 60);
            @(negedge clk);
            if (l_hit) l_hits++;
            if (l_miss) l_misses++;
        end
        btn = 1'b0;
        e = q.pop_front();
        n_cmp++;
        if (l_hits !== 1 || l_misses !== 0) begin
            n_err++;
            $display("FAIL flash_press_pulses: got hits=%0d misses=%0d want 1/0", l_hits, l_misses);
        end
        n_cmp++;
        if (int'(l_tens) !== e.tens || int'(l_ones) !== e.ones || int'(l_lives) !== e.lives) begin
            n_err++;
            $display("FAIL flash_press_score: got %h%h lives=%0d want %0d%0d lives=%0d",
                     l_tens, l_ones, l_lives, e.tens, e.ones, e.lives);
        end
        n_cmp++;
        if (l_playing !== 1'b1 || l_flash !== 1'b0 || l_over !== 1'b0) begin
            n_err++;
            $display("FAIL flash_press_state: got playing=%b flash=%b over=%b want 1/0/0",
                     l_playing, l_flash, l_over);
        end
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h02 || lives !== 2'd3) begin
            n_err++;
            $display("FAIL two_hits: got %h%h lives=%0d want 02 lives=3",
                     score_tens, score_ones, lives);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h02 || lives !== 2'd3 || playing !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_play: got %h%h lives=%0d playing=%b want 02/3/1",
                     score_tens, score_ones, lives, playing);
        end
    endtask

    task automatic test_reset_mid_flash();
        int waited;
        led    = 5'b00001;
        btn    = 1'b1;
        waited = 0;
        while (flash !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (flash !== 1'b1) begin
            n_err++;
            $display("FAIL mid_flash_reach: got flash=%b want 1 within 60 cycles", flash);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        btn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({score_tens, score_ones} !== 8'h00 || lives !== 2'd3
            || {playing, flash, hit_pulse, miss_pulse, game_over} !== 5'b0) begin
            n_err++;
            $display("FAIL rst_mid_flash: got score=%h%h lives=%0d flags=%b want 00/3/00000",
                     score_tens, score_ones, lives,
                     {playing, flash, hit_pulse, miss_pulse, game_over});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        m_score = 0;
        m_lives = 3;
        rst     = 1'b1;
        led     = 5'b00000;
        btn     = 1'b0;
        start   = 1'b0;
        test_reset();
        test_hit();
        test_glitch();
        test_miss_game_over();
        test_saturation();
        test_flash_press_and_start();
        test_reset_mid_flash();
        n_cmp++;
        if (q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/punch_judge.md
# punch_judge

Scoring block for the boxing game. It reads the one-hot LED chaser pattern and the player's punch button, and decides hit or miss on each clean button press. It keeps a two-digit BCD score and a lives counter, and sequences the game through idle, play, feedback flash and game over. It sits between the LED chaser output and the display/indicator logic, on the same clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the debounced button changes state (≥1).
- TARGET_IDX, 4: LED index counted as a hit (0–4).
- START_LIVES, 3: lives loaded at game start (1–3).
- FLASH_CYCLES, 8: duration of the hit/miss feedback flash (≥1).

Ports:
- clk  in  1  system clock; every flop is clocked on posedge.
- rst  in  1  synchronous, active-high reset.
- led  in  5  chaser pattern, same clock domain, nominally one-hot.
- btn  in  1  raw asynchronous punch button, active-high.
- start  in  1  single-cycle start request.
- score_tens  out  4  BCD tens digit.
- score_ones  out  4  BCD ones digit.
- lives  out  2  remaining lives.
- playing  out  1  high in PLAY, HIT_FLASH and MISS_FLASH.
- flash  out  1  high during HIT_FLASH or MISS_FLASH.
- hit_pulse  out  1  one-cycle pulse on a hit.
- miss_pulse  out  1  one-cycle pulse on a miss.
- game_over  out  1  high in GAME_OVER.

## Operation
- Button path: two-flop synchronizer, then debounce. The debounced level takes the synced value once the synced value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreement in between clears the counter.
- A rising edge of the debounced level produces a one-cycle press. Falling edges produce nothing.
- The FSM has five states: IDLE, PLAY, HIT_FLASH, MISS_FLASH, GAME_OVER.
- IDLE, start=1: go to PLAY, clear the score to 00 and load lives=START_LIVES. A press in the same cycle is discarded.
- PLAY, press with led[TARGET_IDX]=1: hit. hit_pulse=1, the score increments in BCD, and the FSM enters HIT_FLASH. Only that bit is examined; other bits are ignored, even when led is not one-hot.
- PLAY, press with led[TARGET_IDX]=0: miss. miss_pulse=1 and lives decrements. If the new lives value is 0, go to GAME_OVER; otherwise go to MISS_FLASH.
- HIT_FLASH / MISS_FLASH: flash=1 for exactly FLASH_CYCLES cycles, then return to PLAY. Presses during a flash are discarded, with no scoring and no lives change.
- GAME_OVER: score and lives are frozen and presses are ignored. start=1 behaves as in IDLE (fresh game, straight into PLAY).
- start in PLAY or in either flash state is ignored.
- Score arithmetic: ones wraps 9→0 with a carry into tens. The score saturates at 99: a hit at 99 still pulses hit_pulse and enters HIT_FLASH, but the score stays 99.
- Lives never underflow; 0 is reachable only via GAME_OVER.

## Timing
- Reset values: state=IDLE, score_tens=0, score_ones=0, lives=START_LIVES, and playing, flash, hit_pulse, miss_pulse and game_over all 0. The synchronizer, debounced level and counters are all cleared.
- rst during any state, including mid-flash or mid-debounce, takes effect at the next edge. A press in progress is lost.
- Button latency: a clean btn rise at edge N gives the internal press in the cycle after the synchronizer output has been stable for DEBOUNCE_CYCLES cycles. That is DEBOUNCE_CYCLES+3 edges after the raw transition.
- Press handling: led is sampled in the same cycle as the press. Score/lives, the state change and hit_pulse/miss_pulse all become visible after the next edge.
- flash rises on the edge that enters the flash state and falls on the edge that returns to PLAY, FLASH_CYCLES cycles later.
- All outputs are registered.

## Structure
- Shared package boxing_pkg holds:
  - the state enum (judge_state_t);
  - the BCD digit type (bcd_t, 4 bits);
  - the constant NUM_LEDS=5.
- Sub-module btn_debounce (synchronizer, debounce counter, rising-edge press output) is reusable for the start button elsewhere.
- The FSM and scoring stay in punch_judge.

## Test plan
- Reset, then start, then btn held high for 20 cycles with led=5'b10000 → one hit_pulse, score 01, flash high for 8 cycles, state returns to PLAY.
- A btn glitch high for 5 cycles (DEBOUNCE_CYCLES=16) → no press, score and lives unchanged.
- Three presses with led=5'b00001, each after its flash has ended → lives 3→2→1→0, two MISS_FLASHes, then game_over=1. A later press changes nothing; start → lives=3, score 00, playing=1.
- Preload 99 hits; the 100th hit → hit_pulse=1, score stays 99. Also check the 09→10 carry on the way.
- A press during HIT_FLASH, and start during PLAY → both ignored. rst asserted mid-flash → every output returns to its reset value after one edge.
